// File: rtl/apu_i2s_transmitter_pkg.sv
// Shared types, constants and sample conversion for the APU I2S transmitter.
package apu_i2s_transmitter_pkg;

  // Channels per I2S frame (mono source duplicated on both).
  localparam int unsigned I2S_SLOTS      = 2;

  // Widest slot the conversion helper supports.
  localparam int unsigned MAX_WORD_WIDTH = 32;

  // Two's-complement zero; the word played before any sample arrives.
  localparam logic [MAX_WORD_WIDTH-1:0] MIDSCALE_WORD = '0;

  // Word-select encoding on o_lrclk.
  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } i2s_slot_e;

  // Offset-binary sample to left-justified two's-complement word (LSBs zero).
  function automatic logic [MAX_WORD_WIDTH-1:0] offset_to_signed(
    input logic [MAX_WORD_WIDTH-1:0] sample,
    input int unsigned               sample_width,
    input int unsigned               word_width
  );
    logic [MAX_WORD_WIDTH-1:0] flipped;
    flipped = sample ^ (MAX_WORD_WIDTH'(1) << (sample_width - 1));
    return flipped << (word_width - sample_width);
  endfunction

endpackage

// File: rtl/apu_i2s_transmitter_clock_divider.sv
// BCLK generator: toggles o_bclk every BCLK_DIV cycles and flags the falling edge.
module apu_i2s_transmitter_clock_divider #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_bclk,
  output logic o_fall_c
);

  localparam int unsigned         CNT_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bclk;
  logic             w_wrap;

  // Wrap marks the cycle whose clock edge toggles BCLK.
  assign w_wrap   = (r_cnt == CNT_MAX);
  assign o_fall_c = w_wrap && r_bclk;
  assign o_bclk   = r_bclk;

  // Half-period counter and bit clock register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_bclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apu_i2s_transmitter.sv
// Mono sample to Philips I2S serialiser with one-entry holding register.
module apu_i2s_transmitter
  import apu_i2s_transmitter_pkg::*;
#(
  parameter int unsigned BCLK_DIV     = 4,
  parameter int unsigned SAMPLE_WIDTH = 9,
  parameter int unsigned WORD_WIDTH   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  output logic                    o_bclk,
  output logic                    o_lrclk,
  output logic                    o_sdata,
  output logic                    o_frame_stb,
  output logic                    o_underrun
);

  localparam int unsigned      FRAME_BITS = I2S_SLOTS * WORD_WIDTH;
  localparam int unsigned      K_W        = $clog2(FRAME_BITS);
  localparam int unsigned      B_W        = $clog2(WORD_WIDTH);
  localparam logic [K_W-1:0]   K_LAST     = K_W'(FRAME_BITS - 1);
  localparam logic [K_W-1:0]   K_WORD     = K_W'(WORD_WIDTH);

  logic                    w_bclk;
  logic                    w_fall;
  logic [K_W-1:0]          r_k;
  logic [K_W-1:0]          w_k_next;
  logic [K_W-1:0]          w_fidx;
  logic [B_W-1:0]          w_bit_sel;
  i2s_slot_e               w_slot_next;
  logic                    w_load;
  logic                    w_accept;
  logic [SAMPLE_WIDTH-1:0] r_hold;
  logic                    r_full;
  logic [WORD_WIDTH-1:0]   r_active;
  logic [WORD_WIDTH-1:0]   w_conv;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_frame_stb;
  logic                    r_underrun;

  apu_i2s_transmitter_clock_divider #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clock_divider (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .o_bclk   (w_bclk),
    .o_fall_c (w_fall)
  );

  // Next bit index, and which word bit goes out after the one-BCLK I2S delay.
  // The bit leaving at index k+1 is frame bit (FRAME_BITS-1-k); both halves carry the same word.
  always_comb begin
    w_k_next    = (r_k == K_LAST) ? '0 : r_k + K_W'(1);
    w_fidx      = K_LAST - r_k;
    w_bit_sel   = (w_fidx >= K_WORD) ? B_W'(w_fidx - K_WORD) : B_W'(w_fidx);
    w_slot_next = (w_k_next >= K_WORD) ? SLOT_RIGHT : SLOT_LEFT;
  end

  assign w_load   = w_fall && (r_k == K_LAST);
  assign w_accept = i_sample_valid && !r_full;
  assign w_conv   = WORD_WIDTH'(offset_to_signed(MAX_WORD_WIDTH'(r_hold), SAMPLE_WIDTH, WORD_WIDTH));

  // Bit index and serial outputs, advanced only on BCLK falling edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k     <= K_LAST;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
    end else if (w_fall) begin
      r_k     <= w_k_next;
      r_lrclk <= (w_slot_next == SLOT_RIGHT);
      r_sdata <= r_active[w_bit_sel];
    end
  end

  // Holding register: filled by the handshake, drained by a frame load (no bypass).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else if (w_load && r_full) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_hold <= i_sample;
      r_full <= 1'b1;
    end
  end

  // Active word: replaced at a frame load only if a sample is waiting, else repeats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= WORD_WIDTH'(MIDSCALE_WORD);
    end else if (w_load && r_full) begin
      r_active <= w_conv;
    end
  end

  // Frame and underrun strobes, aligned with the load edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_stb <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_frame_stb <= w_load;
      r_underrun  <= w_load && !r_full;
    end
  end

  assign o_sample_ready = !r_full;
  assign o_bclk         = w_bclk;
  assign o_lrclk        = r_lrclk;
  assign o_sdata        = r_sdata;
  assign o_frame_stb    = r_frame_stb;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_apu_i2s_transmitter.sv
// Directed bench for apu_i2s_transmitter: timing, frame contents, handshake and reset.
module tb_apu_i2s_transmitter;

  localparam int unsigned BCLK_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [8:0] sample;
  logic       valid;
  logic       o_sample_ready, o_bclk, o_lrclk, o_sdata, o_frame_stb, o_underrun;

  apu_i2s_transmitter #(
    .BCLK_DIV     (BCLK_DIV),
    .SAMPLE_WIDTH (9),
    .WORD_WIDTH   (16)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample       (sample),
    .i_sample_valid (valid),
    .o_sample_ready (o_sample_ready),
    .o_bclk         (o_bclk),
    .o_lrclk        (o_lrclk),
    .o_sdata        (o_sdata),
    .o_frame_stb    (o_frame_stb),
    .o_underrun     (o_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Cycle count since reset release (value n after the n-th rising clock edge).
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Frame decoder: samples the serial line on BCLK rising edges like a DAC.
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    logic        lr_ok;
    logic        und;
  } frame_t;

  frame_t      m_frames [16];
  int          m_wr;
  int          m_cnt;
  logic        m_pend, m_prev_bclk, m_und, m_und_new, m_lr_ok;
  logic [15:0] m_left, m_right;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt       <= -1;
      m_pend      <= 1'b0;
      m_wr        <= 0;
      m_prev_bclk <= 1'b0;
    end else begin
      m_prev_bclk <= o_bclk;
      if (o_frame_stb) begin
        m_pend    <= (m_cnt == 32);
        m_cnt     <= 0;
        m_und_new <= o_underrun;
      end else if (o_bclk && !m_prev_bclk && m_cnt >= 0 && m_cnt < 32) begin
        if (m_cnt == 0) begin
          if (m_pend && m_wr < 16) begin
            m_frames[4'(m_wr)] <= '{left: m_left, right: {m_right[15:1], o_sdata},
                                    lr_ok: m_lr_ok && !o_lrclk, und: m_und};
            m_wr <= m_wr + 1;
          end
          m_pend  <= 1'b0;
          m_und   <= m_und_new;
          m_lr_ok <= !o_lrclk;
        end else begin
          if (m_cnt <= 16) m_left[4'(16 - m_cnt)]  <= o_sdata;
          else             m_right[4'(32 - m_cnt)] <= o_sdata;
          m_lr_ok <= m_lr_ok && (o_lrclk == (m_cnt >= 16));
        end
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic apply_reset();
    rst_n  = 1'b0;
    valid  = 1'b0;
    sample = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_sample(input logic [8:0] s);
    logic done;
    done   = 1'b0;
    sample = s;
    valid  = 1'b1;
    for (int c = 0; c < 600 && !done; c++) begin
      if (o_sample_ready) done = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_stb();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      if (o_frame_stb) seen = 1'b1;
    end
    chk("frame_stb_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_frames(input int n);
    for (int c = 0; c < 600 && m_wr < n; c++) @(negedge clk);
    chk("frames_decoded", 32'(m_wr >= n), 32'd1);
  endtask

  // Idle-line timing after a reset release at a falling clock edge (cyc == 0).
  task automatic timing_check(input string tag);
    int   r1, r2, s1, s2, lr, ones;
    logic u1, u2, pb, plr;
    r1 = -1; r2 = -1; s1 = -1; s2 = -1; lr = -1; ones = 0;
    u1 = 1'b0; u2 = 1'b0; pb = 1'b0; plr = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (o_sdata) ones++;
      if (o_bclk && !pb) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
      if (o_frame_stb) begin
        if (s1 < 0) begin s1 = c; u1 = o_underrun; end
        else if (s2 < 0) begin s2 = c; u2 = o_underrun; end
      end
      if (o_lrclk && !plr && lr < 0) lr = c;
      pb  = o_bclk;
      plr = o_lrclk;
    end
    chk({tag, "_first_rise"},   32'(r1), 32'd4);
    chk({tag, "_second_rise"},  32'(r2), 32'd12);
    chk({tag, "_first_load"},   32'(s1), 32'd8);
    chk({tag, "_first_under"},  32'(u1), 32'd1);
    chk({tag, "_lrclk_rise"},   32'(lr), 32'd136);
    chk({tag, "_second_load"},  32'(s2), 32'd264);
    chk({tag, "_second_under"}, 32'(u2), 32'd1);
    chk({tag, "_sdata_ones"},   32'(ones), 32'd0);
  endtask

  typedef struct {
    logic        send;
    logic [8:0]  smp;
    logic [15:0] exp_word;
    logic        exp_und;
  } vec_t;

  vec_t        vecs [6];
  logic [15:0] cont_exp [3];
  logic        xfer, rdy_checked;
  int          acc;
  logic [8:0]  d;

  initial begin
    vecs[0] = '{1'b1, 9'd511, 16'h7F80, 1'b0};
    vecs[1] = '{1'b1, 9'd0,   16'h8000, 1'b0};
    vecs[2] = '{1'b1, 9'd256, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 9'd384, 16'h4000, 1'b0};
    vecs[4] = '{1'b0, 9'd0,   16'h4000, 1'b1};
    vecs[5] = '{1'b1, 9'd1,   16'h8080, 1'b0};
    cont_exp[0] = 16'hB200;
    cont_exp[1] = 16'hB280;
    cont_exp[2] = 16'hB300;

    rst_n  = 1'b1;
    valid  = 1'b0;
    sample = '0;

    // Reset values, asserted between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_bclk",  32'(o_bclk),         32'd0);
    chk("rst_lrclk", 32'(o_lrclk),        32'd0);
    chk("rst_sdata", 32'(o_sdata),        32'd0);
    chk("rst_stb",   32'(o_frame_stb),    32'd0);
    chk("rst_under", 32'(o_underrun),     32'd0);
    chk("rst_ready", 32'(o_sample_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    timing_check("boot");

    // Table: one sample per frame (or none), checked frame by frame.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].send) send_sample(vecs[i].smp);
      wait_stb();
    end
    wait_frames(6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_left", i),  32'(m_frames[i].left),  32'(vecs[i].exp_word));
      chk($sformatf("vec%0d_right", i), 32'(m_frames[i].right), 32'(vecs[i].exp_word));
      chk($sformatf("vec%0d_under", i), 32'(m_frames[i].und),   32'(vecs[i].exp_und));
      chk($sformatf("vec%0d_lrclk", i), 32'(m_frames[i].lr_ok), 32'd1);
    end

    // Continuous valid with incrementing data: one sample per frame, in order.
    apply_reset();
    d = 9'd100; sample = d; valid = 1'b1; xfer = 1'b0; rdy_checked = 1'b0; acc = 0;
    for (int c = 0; c < 800; c++) begin
      if (xfer) begin
        d = d + 9'd1;
        sample = d;
        if (!rdy_checked) begin
          chk("ready_drop_after_accept", 32'(o_sample_ready), 32'd0);
          rdy_checked = 1'b1;
        end
      end
      xfer = o_sample_ready;
      if (xfer) acc++;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("cont_accepts", 32'(acc), 32'd5);
    wait_frames(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cont%0d_left", i),  32'(m_frames[i].left),  32'(cont_exp[i]));
      chk($sformatf("cont%0d_right", i), 32'(m_frames[i].right), 32'(cont_exp[i]));
      chk($sformatf("cont%0d_under", i), 32'(m_frames[i].und),   32'd0);
    end

    // Accept in the same cycle as an empty-holding load: repeat, then new sample.
    apply_reset();
    send_sample(9'd384);
    for (int c = 0; c < 600 && cyc < 263; c++) @(negedge clk);
    sample = 9'd0;
    valid  = 1'b1;
    @(negedge clk);
    chk("coll_cycle", 32'(cyc),            32'd264);
    chk("coll_stb",   32'(o_frame_stb),    32'd1);
    chk("coll_under", 32'(o_underrun),     32'd1);
    chk("coll_ready", 32'(o_sample_ready), 32'd0);
    valid = 1'b0;
    wait_frames(3);
    chk("coll0_word",  32'(m_frames[0].left),  32'h4000);
    chk("coll0_under", 32'(m_frames[0].und),   32'd0);
    chk("coll1_left",  32'(m_frames[1].left),  32'h4000);
    chk("coll1_right", 32'(m_frames[1].right), 32'h4000);
    chk("coll1_under", 32'(m_frames[1].und),   32'd1);
    chk("coll2_word",  32'(m_frames[2].left),  32'h8000);
    chk("coll2_under", 32'(m_frames[2].und),   32'd0);

    // Asynchronous reset in the middle of the right slot.
    for (int c = 0; c < 400 && !o_lrclk; c++) @(negedge clk);
    repeat (20) @(negedge clk);
    send_sample(9'd5);
    chk("pre_reset_lrclk", 32'(o_lrclk),        32'd1);
    chk("pre_reset_ready", 32'(o_sample_ready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bclk",  32'(o_bclk),         32'd0);
    chk("mid_rst_lrclk", 32'(o_lrclk),        32'd0);
    chk("mid_rst_sdata", 32'(o_sdata),        32'd0);
    chk("mid_rst_stb",   32'(o_frame_stb),    32'd0);
    chk("mid_rst_under", 32'(o_underrun),     32'd0);
    chk("mid_rst_ready", 32'(o_sample_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    timing_check("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
